// File: rtl/eject_packet_buffer_if.sv
// Flit-in / flit-out handshake bundle for the local-port eject buffer.
// slave = buffer side, master = router/receiver side (testbench).
interface eject_packet_buffer_if;
  logic [63:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] Flit;
  logic        write;
  logic        push_ack;

  modport slave  (input  in_flit, in_valid, push_ack,
                  output in_ready, Flit, write);
  modport master (output in_flit, in_valid, push_ack,
                  input  in_ready, Flit, write);
endinterface

// File: rtl/eject_packet_buffer.sv
// Store-and-forward eject buffer for 4-flit packets with framing check.
// Optional destination filter enabled by defining DEST_CHECK_EN.
module eject_packet_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           X_cur,
  input  logic [2:0]           Y_cur,
  eject_packet_buffer_if.slave bus,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 pkt_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] FT_HEAD = 2'b11;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b01;

  typedef enum logic [1:0] {IDLE, B1, B2, T} state_t;

  state_t state, state_n;

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_n, commit_n, wr_addr;
  logic          discard, disc_n;
  logic          wr_en, err_inc, drop_inc;
  logic          acc, full, rd_fire, head_ok;
  logic [1:0]    ftype;

  assign ftype   = bus.in_flit[63:62];
  assign full    = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign bus.in_ready = discard || !full;
  assign acc     = bus.in_valid && bus.in_ready;
  assign bus.write    = (commit_ptr != rd_ptr);
  assign bus.Flit     = mem[rd_ptr[AW-1:0]];
  assign pkt_pending  = bus.write;
  assign rd_fire = bus.write && bus.push_ack;

`ifdef DEST_CHECK_EN
  // While discarding, in_ready ignores fullness; a re-evaluated head that
  // finds no room is treated like a misrouted one so committed data survives.
  logic head_room;
  assign head_room = (commit_ptr - rd_ptr) != PW'(DEPTH);
  assign head_ok   = head_room &&
                     ({bus.in_flit[5:3], bus.in_flit[2:0]} == {Y_cur, X_cur});
`else
  logic unused_dest;
  assign unused_dest = ^{X_cur, Y_cur};
  assign head_ok     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (acc) begin
      if (ftype == FT_HEAD) state_n = B1;
      else begin
        unique case (state)
          IDLE:    state_n = IDLE;
          B1:      state_n = (ftype == FT_BODY) ? B2 : IDLE;
          B2:      state_n = (ftype == FT_BODY) ? T  : IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Outside a packet wr_ptr == commit_ptr, so every head lands at commit_ptr:
  // that single rule covers both a fresh start and rewind-and-restart.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = wr_ptr;
    wr_ptr_n = wr_ptr;
    commit_n = commit_ptr;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    disc_n   = discard;
    if (acc) begin
      if (ftype == FT_HEAD) begin
        err_inc  = (state != IDLE);
        wr_addr  = commit_ptr;
        wr_ptr_n = commit_ptr;
        disc_n   = !head_ok;
        if (head_ok) begin
          wr_en    = 1'b1;
          wr_ptr_n = commit_ptr + PW'(1);
        end
      end else begin
        unique case (state)
          IDLE: err_inc = 1'b1;
          B1, B2: begin
            if (ftype == FT_BODY) begin
              if (!discard) begin
                wr_en    = 1'b1;
                wr_ptr_n = wr_ptr + PW'(1);
              end
            end else begin
              err_inc  = 1'b1;
              wr_ptr_n = commit_ptr;
              disc_n   = 1'b0;
            end
          end
          default: begin
            if (ftype == FT_TAIL) begin
              disc_n = 1'b0;
              if (discard) drop_inc = 1'b1;
              else begin
                wr_en    = 1'b1;
                wr_ptr_n = wr_ptr + PW'(1);
                commit_n = wr_ptr + PW'(1);
              end
            end else begin
              err_inc  = 1'b1;
              wr_ptr_n = commit_ptr;
              disc_n   = 1'b0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      discard    <= 1'b0;
      err_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_n;
      discard    <= disc_n;
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      if (err_inc && (err_cnt != '1))   err_cnt  <= err_cnt + CNT_W'(1);
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[AW-1:0]] <= bus.in_flit;
  end
endmodule

// File: doc/eject_packet_buffer.md
Name: eject_packet_buffer

Overview:
- Local-port ejection stage between the router's local output and the per-node packet receiver.
- Buffers 4-flit packets (head, body, body, tail) store-and-forward and checks flit framing.
- Discards malformed packets, and optionally misrouted ones, so the receiver only sees complete, well-formed packets.
- Presents packets to the receiver over the write/push_ack handshake.

Parameters:
DEPTH, 16, flit storage entries; power of 2, minimum 4.
CNT_W, 16, width of the saturating error and drop counters.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
X_cur  input  3  this node's X coordinate
Y_cur  input  3  this node's Y coordinate
in_flit  input  64  flit from router local output port
in_valid  input  1  in_flit valid
in_ready  output  1  buffer can accept; transfer when in_valid && in_ready
Flit  output  64  flit to receiver
write  output  1  Flit valid toward receiver
push_ack  input  1  receiver accepts; transfer when write && push_ack
err_cnt  output  CNT_W  framing-error count, saturating
drop_cnt  output  CNT_W  misrouted-packet drop count, saturating
pkt_pending  output  1  at least one committed packet not yet fully drained

Behaviour:
- Flit type field: in_flit[63:62]. 11 = head, 10 = body, 01 = tail, 00 = illegal.
- Head destination fields: [2:0] = dest X, [5:3] = dest Y.
- Pointers: wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits, wrapping naturally.
- in_ready = (wr_ptr - rd_ptr) != DEPTH, except when discard=1, where in_ready = 1.
- write = (commit_ptr != rd_ptr). Flit = mem[rd_ptr] combinationally. rd_ptr increments on write && push_ack.
- Framing FSM (advances on accepted flit only): IDLE (expect head) -> B1 -> B2 -> T (expect tail) -> IDLE.
  - IDLE: head -> write it, go B1. Any other type -> not written, err_cnt+1, stay IDLE.
  - B1/B2: body -> write, advance. Head -> rewind wr_ptr to commit_ptr, err_cnt+1, then write this head at commit_ptr (wr_ptr = commit_ptr+1), go B1, all in the same cycle. Tail or 00 -> rewind, err_cnt+1, go IDLE.
  - T: tail -> write, commit_ptr <= wr_ptr+1 (whole packet visible), go IDLE. Head -> rewind-and-restart as above. Body or 00 -> rewind, err_cnt+1, go IDLE.
- Latency: head is never presented before its tail is committed. Tail accepted at edge N -> write=1 in cycle N+1 (first cycle after edge N). Minimum head-in to head-out is 4 cycles.
- Commit and read in the same cycle are both applied. pkt_pending = write.
- Counters saturate at all-ones and do not wrap.
- Full buffer: in_ready=0. A partial packet stalls until the receiver drains committed data. DEPTH>=4 guarantees progress.
- Reset (reset=0 at a clock edge):
  - Pointers 0, FSM IDLE, discard 0, counters 0. Any partial or committed data is lost.
  - Outputs during and after reset: write=0, in_ready=1, err_cnt=0, drop_cnt=0, pkt_pending=0, Flit = don't-care.
  - Reset has priority over all other events.

Optional Feature:
Macro DEST_CHECK_EN.
- Defined:
  - On an accepted head in IDLE with {dest Y, dest X} != {Y_cur, X_cur}: head not written, discard=1.
  - While discard=1: flits are accepted and not written, and the FSM advances as normal.
  - Tail completes the sequence -> drop_cnt+1, discard=0.
  - Framing error during discard -> err_cnt+1, discard=0; a head at that point re-evaluates its destination.
- Not defined: destination ignored, drop_cnt tied to 0, discard never set.

Test Plan:
- X_cur=3, Y_cur=0, push_ack=1. Send head 0xC000_0000_0000_0003, body, body, tail on consecutive cycles -> write first high in the cycle after tail accept; 4 flits out in order, unchanged; err_cnt=0.
- Two back-to-back packets with push_ack=0 for 10 cycles -> write held high, Flit stable on head 1. Then push_ack=1 -> 8 flits out in order, no gaps.
- Body flit first (0x8000...) then a valid packet -> err_cnt=1; only the valid packet emitted.
- Head, body, then new head, body, body, tail -> err_cnt=1; only the second packet emitted (4 flits, starting with the second head).
- DEST_CHECK_EN defined, X_cur=3: packet with dest X=2, then a packet with dest X=3 -> drop_cnt=1; only the second packet emitted.
- DEPTH=8, push_ack=0, offer 3 packets -> in_ready=0 after 8 flits accepted. Assert push_ack=1 -> third packet accepted and all 12 flits emitted. Apply reset=0 mid-packet -> write=0, counters 0.
